// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences register-transfer commands (LOAD/CLR/MOVE/SWAP)
// onto a shared tri-state register bus. All enables are registered, and no
// cycle ever has more than one bus driver or more than one load target.
module bus_xfer_ctrl #(
  parameter int unsigned NREG = 4,
  parameter int unsigned SELW = 2,
  parameter int unsigned W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [SELW-1:0] cmd_src,
  input  logic [SELW-1:0] cmd_dst,
  input  logic [W-1:0]    cmd_imm,
  output logic [NREG-1:0] reg_in,
  output logic [NREG-1:0] reg_out,
  output logic            tmp_in,
  output logic            tmp_out,
  output logic            ext_out,
  output logic [W-1:0]    imm_out,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    FIN  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOVE = 2'b01,
    OP_SWAP = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  // Register count widened by one bit so an out-of-range select can be detected.
  localparam logic [SELW:0] NREG_L = (SELW+1)'(NREG);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [SELW-1:0] src_q, src_d;
  logic [SELW-1:0] dst_q, dst_d;
  logic [W-1:0]    imm_q, imm_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [NREG-1:0] rin_q, rin_d;
  logic [NREG-1:0] rout_q, rout_d;
  logic            tin_q, tin_d;
  logic            tout_q, tout_d;
  logic            ext_q, ext_d;
  logic [W-1:0]    immo_q, immo_d;

  logic            accept;
  logic            bad;

  // Decode a register select into a one-hot enable vector.
  function automatic logic [NREG-1:0] sel_onehot(input logic [SELW-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (idx == SELW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign accept = cmd_valid && ready_q;

  // Effective command: fresh inputs on the accept edge, otherwise the captured copy.
  // Using it for the output decode lets step 1's enables register on the accept edge.
  always_comb begin
    op_d  = op_q;
    src_d = src_q;
    dst_d = dst_q;
    imm_d = imm_q;
    if (accept) begin
      op_d  = op_e'(cmd_op);
      src_d = cmd_src;
      dst_d = cmd_dst;
      imm_d = cmd_imm;
    end
  end

  // Reject out-of-range selects, and source/destination aliasing for MOVE/SWAP.
  always_comb begin
    bad = ({1'b0, dst_d} >= NREG_L);
    if (op_d == OP_MOVE || op_d == OP_SWAP) begin
      bad = bad || ({1'b0, src_d} >= NREG_L) || (src_d == dst_d);
    end
  end

  // Next-state, handshake and completion pulses.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          state_d = bad ? FIN : S1;
        end
      end
      S1: begin
        if (op_q == OP_SWAP) begin
          state_d = S2;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      S2: begin
        state_d = S3;
      end
      S3: begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      FIN: begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // Bus enables for the step being entered; IDLE and FIN leave everything off.
  always_comb begin
    rin_d  = '0;
    rout_d = '0;
    tin_d  = 1'b0;
    tout_d = 1'b0;
    ext_d  = 1'b0;
    immo_d = '0;
    case (state_d)
      S1: begin
        case (op_d)
          OP_LOAD: begin
            ext_d  = 1'b1;
            immo_d = imm_d;
            rin_d  = sel_onehot(dst_d);
          end
          OP_CLR: begin
            ext_d  = 1'b1;
            rin_d  = sel_onehot(dst_d);
          end
          OP_MOVE: begin
            rout_d = sel_onehot(src_d);
            rin_d  = sel_onehot(dst_d);
          end
          OP_SWAP: begin
            rout_d = sel_onehot(src_d);
            tin_d  = 1'b1;
          end
        endcase
      end
      S2: begin
        rout_d = sel_onehot(dst_d);
        rin_d  = sel_onehot(src_d);
      end
      S3: begin
        tout_d = 1'b1;
        rin_d  = sel_onehot(dst_d);
      end
      default: ;
    endcase
  end

  // Control state, handshake and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Captured command fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_LOAD;
      src_q <= '0;
      dst_q <= '0;
      imm_q <= '0;
    end else begin
      op_q  <= op_d;
      src_q <= src_d;
      dst_q <= dst_d;
      imm_q <= imm_d;
    end
  end

  // Registered bus enables; reset drops them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rin_q  <= '0;
      rout_q <= '0;
      tin_q  <= 1'b0;
      tout_q <= 1'b0;
      ext_q  <= 1'b0;
      immo_q <= '0;
    end else begin
      rin_q  <= rin_d;
      rout_q <= rout_d;
      tin_q  <= tin_d;
      tout_q <= tout_d;
      ext_q  <= ext_d;
      immo_q <= immo_d;
    end
  end

  assign cmd_ready = ready_q;
  assign reg_in    = rin_q;
  assign reg_out   = rout_q;
  assign tmp_in    = tin_q;
  assign tmp_out   = tout_q;
  assign ext_out   = ext_q;
  assign imm_out   = immo_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a register-file datapath driven by the DUT enables,
// a command-level register model, a vector table, hand sequences and random commands.
module tb_bus_xfer_ctrl;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op, cmd_src, cmd_dst;
  logic [3:0] cmd_imm;
  logic [3:0] reg_in, reg_out;
  logic       tmp_in, tmp_out, ext_out;
  logic [3:0] imm_out;
  logic       busy, done, err;

  // Second instance with three registers, exercising out-of-range selects.
  logic       c3_valid, c3_ready;
  logic [2:0] c3_reg_in, c3_reg_out;
  logic       c3_tmp_in, c3_tmp_out, c3_ext_out;
  logic [3:0] c3_imm_out;
  logic       c3_busy, c3_done, c3_err;

  int checks = 0;
  int errors = 0;

  bus_xfer_ctrl #(.NREG(4), .SELW(2), .W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .reg_in(reg_in), .reg_out(reg_out), .tmp_in(tmp_in), .tmp_out(tmp_out),
    .ext_out(ext_out), .imm_out(imm_out), .busy(busy), .done(done), .err(err)
  );

  bus_xfer_ctrl #(.NREG(3), .SELW(2), .W(4)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .reg_in(c3_reg_in), .reg_out(c3_reg_out), .tmp_in(c3_tmp_in), .tmp_out(c3_tmp_out),
    .ext_out(c3_ext_out), .imm_out(c3_imm_out), .busy(c3_busy), .done(c3_done), .err(c3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Register datapath driven by the DUT's enables.
  logic [3:0] R [4];
  logic [3:0] T, bus;
  logic       dp_clr;

  always_comb begin
    bus = '0;
    for (int i = 0; i < 4; i++) if (reg_out[i]) bus = bus | R[i];
    if (tmp_out) bus = bus | T;
    if (ext_out) bus = bus | imm_out;
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 4; i++) R[i] <= '0;
      T <= '0;
    end else begin
      for (int i = 0; i < 4; i++) if (reg_in[i]) R[i] <= bus;
      if (tmp_in) T <= bus;
    end
  end

  // Per-cycle bus invariants.
  always @(negedge clk) begin
    chk("one_driver", 32'($onehot0({reg_out, tmp_out, ext_out})), 32'd1);
    chk("one_loader", 32'($onehot0({reg_in, tmp_in})), 32'd1);
    if (!ext_out) chk("imm_when_off", 32'(imm_out), 32'd0);
    if (!busy) chk("idle_quiet", 32'({reg_in, reg_out, tmp_in, tmp_out, ext_out}), 32'd0);
    chk("err_without_done", 32'(err && !done), 32'd0);
  end

  // Command-level register model.
  logic [3:0] M [4];

  typedef struct packed {
    logic [3:0] rin;
    logic [3:0] rout;
    logic       tin;
    logic       tout;
    logic       ext;
    logic [3:0] imm;
  } step_t;

  function automatic bit bad_ref(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst);
    if (op == 2'd1 || op == 2'd2) return (src == dst);
    return 1'b0;
  endfunction

  function automatic step_t exp_step(input logic [1:0] op, input logic [1:0] src,
                                     input logic [1:0] dst, input logic [3:0] imm,
                                     input bit bad, input int j);
    step_t s;
    logic [3:0] sh, dh;
    s  = '0;
    sh = 4'b0001 << src;
    dh = 4'b0001 << dst;
    if (!bad) begin
      case (op)
        2'd0: begin s.ext = 1'b1; s.imm = imm; s.rin = dh; end
        2'd3: begin s.ext = 1'b1; s.rin = dh; end
        2'd1: begin s.rout = sh; s.rin = dh; end
        2'd2: begin
          if (j == 0) begin s.rout = sh; s.tin = 1'b1; end
          else if (j == 1) begin s.rout = dh; s.rin = sh; end
          else begin s.tout = 1'b1; s.rin = dh; end
        end
      endcase
    end
    return s;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command at a negedge with ready high, check every step and the
  // done cycle. Garbage with valid high is presented while busy.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] imm, input bit exp_err, input int exp_lat);
    step_t e;
    logic [3:0] t;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
    @(posedge clk);
    for (int j = 0; j < exp_lat - 1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        cmd_op  = 2'($urandom);
        cmd_src = 2'($urandom);
        cmd_dst = 2'($urandom);
        cmd_imm = 4'($urandom);
      end
      e = exp_step(op, src, dst, imm, exp_err, j);
      chk("step_reg_in", 32'(reg_in), 32'(e.rin));
      chk("step_reg_out", 32'(reg_out), 32'(e.rout));
      chk("step_tmp", 32'({tmp_in, tmp_out}), 32'({e.tin, e.tout}));
      chk("step_ext", 32'({ext_out, imm_out}), 32'({e.ext, e.imm}));
      chk("step_busy", 32'(busy), 32'd1);
      chk("step_ready", 32'(cmd_ready), 32'd0);
      chk("step_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'(exp_err));
    chk("done_ready", 32'(cmd_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    if (!exp_err) begin
      case (op)
        2'd0: M[dst] = imm;
        2'd3: M[dst] = '0;
        2'd1: M[dst] = M[src];
        default: begin t = M[src]; M[src] = M[dst]; M[dst] = t; end
      endcase
    end
    for (int i = 0; i < 4; i++) chk($sformatf("reg_R%0d", i), 32'(R[i]), 32'(M[i]));
  endtask

  task automatic run3(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                      input logic [3:0] imm, input bit exp_err, input logic [2:0] exp_rin);
    int n;
    n = 0;
    while (c3_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("n3_ready", 32'(c3_ready), 32'd1);
    c3_valid = 1'b1;
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
    @(posedge clk);
    @(negedge clk);
    c3_valid = 1'b0;
    chk("n3_busy", 32'(c3_busy), 32'd1);
    chk("n3_reg_in", 32'(c3_reg_in), 32'(exp_rin));
    chk("n3_drivers", 32'({c3_reg_out, c3_tmp_in, c3_tmp_out}), 32'd0);
    @(negedge clk);
    chk("n3_done", 32'(c3_done), 32'd1);
    chk("n3_err", 32'(c3_err), 32'(exp_err));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] imm;
    bit         err;
    int         lat;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // op: 0 LOAD, 1 MOVE, 2 SWAP, 3 CLR
    tbl[0]  = '{2'd0, 2'd0, 2'd1, 4'hA, 1'b0, 2};
    tbl[1]  = '{2'd0, 2'd0, 2'd0, 4'h3, 1'b0, 2};
    tbl[2]  = '{2'd0, 2'd0, 2'd2, 4'hC, 1'b0, 2};
    tbl[3]  = '{2'd1, 2'd0, 2'd2, 4'h0, 1'b0, 2};
    tbl[4]  = '{2'd0, 2'd0, 2'd1, 4'h5, 1'b0, 2};
    tbl[5]  = '{2'd0, 2'd0, 2'd3, 4'h9, 1'b0, 2};
    tbl[6]  = '{2'd2, 2'd1, 2'd3, 4'h0, 1'b0, 4};
    tbl[7]  = '{2'd1, 2'd2, 2'd2, 4'h0, 1'b1, 2};
    tbl[8]  = '{2'd2, 2'd0, 2'd0, 4'h0, 1'b1, 2};
    tbl[9]  = '{2'd0, 2'd0, 2'd1, 4'h7, 1'b0, 2};
    tbl[10] = '{2'd1, 2'd1, 2'd0, 4'h0, 1'b0, 2};
    tbl[11] = '{2'd3, 2'd0, 2'd1, 4'hF, 1'b0, 2};
    tbl[12] = '{2'd2, 2'd3, 2'd1, 4'h0, 1'b0, 4};
    tbl[13] = '{2'd0, 2'd2, 2'd2, 4'h1, 1'b0, 2};
    tbl[14] = '{2'd3, 2'd3, 2'd3, 4'h6, 1'b0, 2};

    rst = 1'b1; dp_clr = 1'b1;
    cmd_valid = 1'b0; c3_valid = 1'b0;
    cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_imm = '0;
    for (int i = 0; i < 4; i++) M[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_flags", 32'({busy, done, err}), 32'd0);
    chk("rst_enables", 32'({reg_in, reg_out, tmp_in, tmp_out, ext_out, imm_out}), 32'd0);
    rst = 1'b0; dp_clr = 1'b0;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(cmd_ready), 32'd1);

    // Vector table, issued back-to-back.
    for (int k = 0; k < 15; k++) begin
      run_cmd(tbl[k].op, tbl[k].src, tbl[k].dst, tbl[k].imm, tbl[k].err, tbl[k].lat);
    end

    // Three-register instance: selects of 3 are out of range.
    @(negedge clk);
    run3(2'd2, 2'd0, 2'd3, 4'h0, 1'b1, 3'b000);
    run3(2'd1, 2'd3, 2'd1, 4'h0, 1'b1, 3'b000);
    run3(2'd0, 2'd0, 2'd3, 4'h4, 1'b1, 3'b000);
    run3(2'd3, 2'd1, 2'd3, 4'h0, 1'b1, 3'b000);
    run3(2'd0, 2'd3, 2'd2, 4'h6, 1'b0, 3'b100);
    run3(2'd1, 2'd2, 2'd2, 4'h0, 1'b1, 3'b000);

    // Randomized commands with random idle gaps.
    for (int k = 0; k < 150; k++) begin
      logic [1:0] op, src, dst;
      logic [3:0] imm;
      bit b;
      op  = 2'($urandom_range(0, 3));
      src = 2'($urandom_range(0, 3));
      dst = 2'($urandom_range(0, 3));
      imm = 4'($urandom);
      b   = bad_ref(op, src, dst);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(op, src, dst, imm, b, b ? 2 : ((op == 2'd2) ? 4 : 2));
    end

    // Reset during S2 of a SWAP: enables drop at once, no done, nothing written.
    run_cmd(2'd0, 2'd0, 2'd1, 4'h5, 1'b0, 2);
    run_cmd(2'd0, 2'd0, 2'd3, 4'h9, 1'b0, 2);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = 2'd2; cmd_src = 2'd1; cmd_dst = 2'd3; cmd_imm = 4'h0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rs_s1_out", 32'({reg_out, tmp_in}), 32'b00101);
    @(negedge clk);
    chk("rs_s2_en", 32'({reg_out, reg_in}), 32'b10000010);
    #1 rst = 1'b1;
    #1;
    chk("rs_enables", 32'({reg_in, reg_out, tmp_in, tmp_out, ext_out, imm_out}), 32'd0);
    chk("rs_flags", 32'({cmd_ready, busy, done, err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rs_ready_held", 32'(cmd_ready), 32'd0);
    chk("rs_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("rs_ready_back", 32'(cmd_ready), 32'd1);
    chk("rs_idle", 32'({busy, done}), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rs_R%0d", i), 32'(R[i]), 32'(M[i]));
    run_cmd(2'd1, 2'd3, 2'd0, 4'h0, 1'b0, 2);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
